// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_RAS
  } owner_t;

  localparam logic [2:0] RAS_STRCTRL_WORD = 3'b100;
  localparam logic [3:0] WEN_ALL          = 4'b1111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned    W   = 4,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the block-memory data port between CPU loads/stores and the RAS
// spill/fill engine: CPU priority with a bounded-wait forced grant for RAS.
module dmem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h0000_2000,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_mmio,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_din,
  input  logic [3:0]        cpu_be,
  input  logic [2:0]        cpu_strctrl,
  output logic              cpu_hold,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ras_rd,
  input  logic              ras_wr,
  input  logic [31:0]       ras_addr,
  input  logic [31:0]       ras_din,
  output logic              ras_gnt,
  output logic [31:0]       ras_rdata,
  output logic              ras_rvalid,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_din,
  output logic [2:0]        mem_strctrl,
  input  logic [31:0]       mem_dout,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_forced
);

  // A zero-width counter is illegal; with MAX_WAIT = 0 a 1-bit counter pinned
  // at 0 makes every RAS request a forced grant.
  localparam int unsigned       WAIT_W   = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              cpu_act, ras_act;
  logic              gnt_cpu, gnt_ras;
  logic              wait_clr, stat_inc;
  logic [WAIT_W-1:0] wait_cnt;
  owner_t            owner_q, owner_d;

  always_comb begin
    cpu_act  = (cpu_rd | cpu_wr) & ~cpu_mmio;
    ras_act  = ras_rd | ras_wr;
    gnt_ras  = ras_act & (~cpu_act | (wait_cnt == WAIT_MAX));
    gnt_cpu  = cpu_act & ~gnt_ras;
    wait_clr = ~ras_act | gnt_ras;
    stat_inc = gnt_ras & cpu_act;
  end

  sat_counter #(
    .W   (WAIT_W),
    .MAX (WAIT_MAX)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (wait_clr),
    .inc_i   (1'b1),
    .count_o (wait_cnt)
  );

  sat_counter #(
    .W (STAT_W)
  ) u_stat_forced (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (stat_clr),
    .inc_i   (stat_inc),
    .count_o (stat_forced)
  );

  assign ras_gnt  = gnt_ras;
  assign cpu_hold = cpu_act & gnt_ras;
  assign mem_en   = gnt_ras | gnt_cpu;

  always_comb begin
    mem_wen     = '0;
    mem_strctrl = '0;
    mem_addr    = cpu_addr - MEM_BASE;
    mem_din     = cpu_din;
    if (gnt_ras) begin
      mem_addr = ras_addr - MEM_BASE;
      mem_din  = ras_din;
      if (ras_wr) begin
        mem_wen     = WEN_ALL;
        mem_strctrl = RAS_STRCTRL_WORD;
      end
    end else if (gnt_cpu && cpu_wr) begin
      mem_wen     = cpu_be;
      mem_strctrl = cpu_strctrl;
    end
  end

  // Tracks which requester owns the read data returning next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_cpu && cpu_rd && !cpu_wr) begin
      owner_d = OWN_CPU;
    end else if (gnt_ras && !ras_wr) begin
      owner_d = OWN_RAS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign ras_rvalid = (owner_q == OWN_RAS);
  assign cpu_rdata  = mem_dout;
  assign ras_rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a cycle model.
module tb_dmem_port_arbiter;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int          MW   = 4;
  localparam int          SW   = 2;
  localparam int          SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd, cpu_wr, cpu_mmio;
  logic [31:0]   cpu_addr, cpu_din;
  logic [3:0]    cpu_be;
  logic [2:0]    cpu_strctrl;
  logic          cpu_hold;
  logic [31:0]   cpu_rdata;
  logic          cpu_rvalid;
  logic          ras_rd, ras_wr;
  logic [31:0]   ras_addr, ras_din;
  logic          ras_gnt;
  logic [31:0]   ras_rdata;
  logic          ras_rvalid;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [31:0]   mem_addr, mem_din;
  logic [2:0]    mem_strctrl;
  logic [31:0]   mem_dout;
  logic          stat_clr;
  logic [SW-1:0] stat_forced;

  dmem_port_arbiter #(
    .MEM_BASE (BASE),
    .MAX_WAIT (MW),
    .STAT_W   (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_mmio    (cpu_mmio),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_be      (cpu_be),
    .cpu_strctrl (cpu_strctrl),
    .cpu_hold    (cpu_hold),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .ras_rd      (ras_rd),
    .ras_wr      (ras_wr),
    .ras_addr    (ras_addr),
    .ras_din     (ras_din),
    .ras_gnt     (ras_gnt),
    .ras_rdata   (ras_rdata),
    .ras_rvalid  (ras_rvalid),
    .mem_en      (mem_en),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_strctrl (mem_strctrl),
    .mem_dout    (mem_dout),
    .stat_clr    (stat_clr),
    .stat_forced (stat_forced)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state: RAS denial streak, who owns next-cycle read data, forced count.
  int m_denied = 0;
  int m_pend   = 0;   // 0 none, 1 cpu, 2 ras
  int m_stat   = 0;
  bit e_ca, e_ra, e_gr, e_gc;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic eval_model();
    e_ca = (cpu_rd || cpu_wr) && !cpu_mmio;
    e_ra = ras_rd || ras_wr;
    e_gr = e_ra && (!e_ca || m_denied >= MW);
    e_gc = e_ca && !e_gr;
  endtask

  task automatic check_comb();
    #1;
    eval_model();
    check_eq("ras_gnt", 32'(ras_gnt), 32'(e_gr));
    check_eq("cpu_hold", 32'(cpu_hold), 32'(e_ca && e_gr));
    check_eq("mem_en", 32'(mem_en), 32'(e_gr || e_gc));
    if (e_gr) begin
      check_eq("mem_wen_ras", 32'(mem_wen), ras_wr ? 32'hF : 32'h0);
      check_eq("mem_strctrl_ras", 32'(mem_strctrl), ras_wr ? 32'h4 : 32'h0);
      check_eq("mem_addr_ras", mem_addr, ras_addr - BASE);
      if (ras_wr) check_eq("mem_din_ras", mem_din, ras_din);
    end else if (e_gc) begin
      check_eq("mem_addr_cpu", mem_addr, cpu_addr - BASE);
      check_eq("mem_wen_cpu", 32'(mem_wen), cpu_wr ? 32'(cpu_be) : 32'h0);
      if (cpu_wr) begin
        check_eq("mem_din_cpu", mem_din, cpu_din);
        check_eq("mem_strctrl_cpu", 32'(mem_strctrl), 32'(cpu_strctrl));
      end
    end else begin
      check_eq("mem_wen_idle", 32'(mem_wen), 32'h0);
    end
    check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1));
    check_eq("ras_rvalid", 32'(ras_rvalid), 32'(m_pend == 2));
    if (m_pend == 1) check_eq("cpu_rdata", cpu_rdata, mem_dout);
    if (m_pend == 2) check_eq("ras_rdata", ras_rdata, mem_dout);
    check_eq("stat_forced", 32'(stat_forced), 32'(m_stat));
  endtask

  task automatic tick();
    int n_denied, n_pend, n_stat;
    eval_model();
    if (rst) begin
      n_denied = 0; n_pend = 0; n_stat = 0;
    end else begin
      n_pend   = (e_gc && cpu_rd && !cpu_wr) ? 1 : (e_gr && !ras_wr) ? 2 : 0;
      n_denied = (e_ra && !e_gr) ? min2(m_denied + 1, MW) : 0;
      n_stat   = stat_clr ? 0 : (e_gr && e_ca) ? min2(m_stat + 1, SMAX) : m_stat;
    end
    @(posedge clk);
    m_denied = n_denied; m_pend = n_pend; m_stat = n_stat;
    @(negedge clk);
    mem_dout = $urandom;
  endtask

  task automatic idle();
    cpu_rd = 0; cpu_wr = 0; cpu_mmio = 0; ras_rd = 0; ras_wr = 0; stat_clr = 0;
  endtask

  bit last_gr = 0;

  initial begin
    rst = 1; idle();
    cpu_addr = '0; cpu_din = '0; cpu_be = '0; cpu_strctrl = '0;
    ras_addr = '0; ras_din = '0; mem_dout = '0;
    @(negedge clk);
    tick(); tick();
    rst = 0;

    // reset state
    check_comb();
    check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check_eq("rst_stat", 32'(stat_forced), 32'h0);
    tick();

    // CPU-only load
    cpu_rd = 1; cpu_addr = 32'h2010;
    check_comb();
    check_eq("cpu_only_addr", mem_addr, 32'h10);
    check_eq("cpu_only_hold", 32'(cpu_hold), 32'h0);
    tick(); idle();
    check_comb();
    check_eq("cpu_only_rvalid", 32'(cpu_rvalid), 32'h1);
    tick();

    // RAS write with CPU idle
    ras_wr = 1; ras_addr = 32'h3000; ras_din = 32'hDEADBEEF;
    check_comb();
    check_eq("ras_wr_gnt", 32'(ras_gnt), 32'h1);
    check_eq("ras_wr_wen", 32'(mem_wen), 32'hF);
    check_eq("ras_wr_strctrl", 32'(mem_strctrl), 32'h4);
    check_eq("ras_wr_addr", mem_addr, 32'h1000);
    tick(); idle();

    // starvation guard: forced grant every MW+1 cycles
    cpu_rd = 1; cpu_addr = 32'h2040; ras_rd = 1; ras_addr = 32'h2100;
    for (int c = 0; c < 10; c++) begin
      check_comb();
      check_eq("starve_gnt", 32'(ras_gnt), 32'((c == 4) || (c == 9)));
      if (c == 4) check_eq("starve_hold", 32'(cpu_hold), 32'h1);
      if (c == 5) begin
        check_eq("starve_rvalid", 32'(ras_rvalid), 32'h1);
        check_eq("starve_stat", 32'(stat_forced), 32'h1);
      end
      tick();
    end
    idle();

    // MMIO store overlapping a RAS read
    cpu_wr = 1; cpu_mmio = 1; ras_rd = 1;
    check_comb();
    check_eq("mmio_gnt", 32'(ras_gnt), 32'h1);
    check_eq("mmio_hold", 32'(cpu_hold), 32'h0);
    tick(); idle();
    check_comb();
    check_eq("mmio_stat", 32'(stat_forced), 32'h2);
    tick();

    // reset while a CPU read is being granted
    cpu_rd = 1; rst = 1;
    check_comb();
    tick(); idle(); rst = 0;
    check_comb();
    check_eq("rst_mid_rvalid", 32'(cpu_rvalid), 32'h0);
    check_eq("rst_mid_stat", 32'(stat_forced), 32'h0);
    tick();

    // forced-grant counter saturation, then clear racing an increment
    cpu_rd = 1; ras_rd = 1;
    for (int c = 0; c < 26; c++) begin
      check_comb();
      tick();
    end
    check_comb();
    check_eq("stat_sat", 32'(stat_forced), 32'(SMAX));
    for (int c = 0; c < 10 && m_denied != MW; c++) begin
      tick();
      check_comb();
    end
    stat_clr = 1;
    check_comb();
    check_eq("clr_race_gnt", 32'(ras_gnt), 32'h1);
    tick(); stat_clr = 0; idle();
    check_comb();
    check_eq("clr_race_stat", 32'(stat_forced), 32'h0);
    tick();

    // randomized traffic; RAS keeps its request until granted
    for (int c = 0; c < 600; c++) begin
      if ((!ras_rd && !ras_wr) || last_gr) begin
        ras_rd   = ($urandom_range(0, 3) != 0);
        ras_wr   = ($urandom_range(0, 2) == 0);
        ras_addr = $urandom;
        ras_din  = $urandom;
      end
      cpu_rd      = ($urandom_range(0, 3) != 0);
      cpu_wr      = ($urandom_range(0, 2) == 0);
      cpu_mmio    = ($urandom_range(0, 7) == 0);
      cpu_addr    = $urandom;
      cpu_din     = $urandom;
      cpu_be      = 4'($urandom);
      cpu_strctrl = 3'($urandom);
      stat_clr    = ($urandom_range(0, 15) == 0);
      check_comb();
      last_gr = e_gr;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the single data port of the shared block memory between the CPU load/store path and the return-address-stack (RAS) spill/fill engine.
- Replaces "RAS only when CPU idle" sharing with CPU-priority arbitration plus a bounded-wait starvation guard that stalls the CPU via cpu_hold.
- Tags synchronous-read responses back to the owning requester.
- Sits between the memory controller's region decode and the memory interface data port.

Parameters:
- MEM_BASE, 32'h0000_2000: subtracted from the granted address before driving mem_addr.
- MAX_WAIT, 4: cycles RAS may be denied before a forced grant; 0 gives RAS absolute priority.
- STAT_W, 16: width of the forced-grant statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cpu_rd  in  1  CPU load request
- cpu_wr  in  1  CPU store request
- cpu_mmio  in  1  CPU address in MMIO region; request never reaches memory
- cpu_addr  in  32  CPU byte address
- cpu_din  in  32  CPU store data
- cpu_be  in  4  CPU byte write enables
- cpu_strctrl  in  3  CPU store control
- cpu_hold  out  1  CPU must stall and keep its request stable
- cpu_rdata  out  32  load data (= mem_dout)
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- ras_rd  in  1  RAS read request
- ras_wr  in  1  RAS write request
- ras_addr  in  32  RAS byte address
- ras_din  in  32  RAS write data
- ras_gnt  out  1  RAS request accepted this cycle
- ras_rdata  out  32  read data (= mem_dout)
- ras_rvalid  out  1  ras_rdata valid this cycle
- mem_en  out  1  memory port enable
- mem_wen  out  4  byte write enables
- mem_addr  out  32  granted address - MEM_BASE
- mem_din  out  32  write data
- mem_strctrl  out  3  store control
- mem_dout  in  32  memory read data, 1-cycle latency
- stat_clr  in  1  clear forced-grant counter
- stat_forced  out  STAT_W  saturating count of forced RAS grants

Behaviour:
- Request terms:
  - cpu_act = (cpu_rd | cpu_wr) & ~cpu_mmio
  - ras_act = ras_rd | ras_wr
  - ras_rd & ras_wr together is treated as a write.
- Grant (combinational, same cycle):
  - gnt_ras = ras_act & (~cpu_act | wait_cnt == MAX_WAIT)
  - gnt_cpu = cpu_act & ~gnt_ras
- Outputs:
  - ras_gnt = gnt_ras
  - cpu_hold = cpu_act & gnt_ras; combinational, no registered stage
- Mux on gnt_ras:
  - RAS write: mem_wen = 4'b1111, mem_strctrl = 3'b100.
  - RAS read: mem_wen = 0, mem_strctrl = 0.
  - CPU write: mem_wen = cpu_be, mem_strctrl = cpu_strctrl.
  - CPU read: mem_wen = 0.
  - mem_en = gnt_ras | gnt_cpu.
  - No grant: mem_en = 0, mem_wen = 0; mem_addr/mem_din don't-care.
- Address: mem_addr = granted address - MEM_BASE, modulo 2^32 (underflow wraps, no check).
- wait_cnt, width $clog2(MAX_WAIT+1):
  - Clears when ~ras_act or gnt_ras.
  - Otherwise increments, saturating at MAX_WAIT.
  - A forced grant therefore clears the counter, so the CPU is guaranteed MAX_WAIT owned cycles before the next forced grant.
  - MAX_WAIT = 0: RAS can starve the CPU indefinitely (documented, allowed).
- Response FSM, state rd_owner ∈ {NONE, CPU, RAS}:
  - Registered each cycle: CPU if gnt_cpu & cpu_rd & ~cpu_wr; RAS if gnt_ras & ~ras_wr; else NONE.
  - cpu_rvalid = (rd_owner == CPU); ras_rvalid = (rd_owner == RAS).
  - Valid is exactly one cycle after the grant; reads are back-to-back capable.
  - cpu_rdata and ras_rdata are both wired to mem_dout; the consumer qualifies with its valid.
- stat_forced:
  - +1 when gnt_ras & cpu_act; saturates at all-ones.
  - stat_clr has priority over increment (clr & event → 0).
- Reset (synchronous), including mid-operation:
  - wait_cnt = 0, rd_owner = NONE, stat_forced = 0.
  - A read granted in the reset cycle produces no rvalid.
  - Combinational outputs follow inputs during reset; requesters must not request while rst is high.
- MMIO accesses (cpu_mmio = 1) never hold the CPU and leave the port free for RAS.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CPU, OWN_RAS}
  - constant RAS_STRCTRL_WORD = 3'b100
  - constant WEN_ALL = 4'b1111
- Sub-module sat_counter (parameterised width, inc, clr, saturate); instantiated for wait_cnt and stat_forced.

Test Plan:
- CPU-only: cpu_rd at addr 0x2010, no RAS → mem_en = 1, mem_addr = 0x10, cpu_hold = 0; next cycle cpu_rvalid = 1, cpu_rdata = mem_dout.
- Idle-CPU RAS write: ras_wr, addr 0x3000, din 0xDEADBEEF → ras_gnt = 1 same cycle, mem_wen = 4'hF, mem_strctrl = 3'b100, mem_addr = 0x1000.
- Starvation, MAX_WAIT = 4: CPU requests every cycle, ras_rd held → ras_gnt = 0 for 4 cycles, ras_gnt = 1 and cpu_hold = 1 in cycle 5, ras_rvalid in cycle 6, stat_forced = 1; CPU owns the next 4 cycles.
- MMIO overlap: cpu_wr with cpu_mmio = 1 plus ras_rd → ras_gnt = 1, cpu_hold = 0, stat_forced unchanged.
- Reset mid-read: gnt_cpu read, rst asserted the same cycle → cpu_rvalid = 0 next cycle; wait_cnt and stat_forced read 0.
- Counter saturation: STAT_W = 2, force 5 grants → stat_forced = 3; stat_clr concurrent with a forced grant → 0.
